tqvp_uart_tx_fifo: RTL and testbench



---
 rtl/tqvp_uart_tx_fifo.sv | 267 ++++++++++++++++++++++++++
 tb/tb_tqvp_uart_tx_fifo.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tqvp_uart_tx_fifo.sv
// tqvp_uart_tx_fifo: TinyQV transmit UART peripheral.
// CPU-written bytes are queued in a FIFO and sent as 8N1 frames on uo_out[0]
// at a programmable baud divisor (bit time = DIV+1 clocks).
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit per frame
// and advertises it in STATUS bit 4.
module tqvp_uart_tx_fifo #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [15:0] DIV_RESET  = 16'd555
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    localparam logic [3:0] ADDR_TXDATA = 4'h0;
    localparam logic [3:0] ADDR_STATUS = 4'h1;
    localparam logic [3:0] ADDR_DIV_LO = 4'h2;
    localparam logic [3:0] ADDR_DIV_HI = 4'h3;
    localparam logic [3:0] ADDR_CTRL   = 4'h4;
    localparam logic [3:0] ADDR_COUNT  = 4'h5;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd4;
    localparam logic       PARITY_FEATURE = 1'b1;
`else
    localparam logic       PARITY_FEATURE = 1'b0;
`endif

    // FIFO storage and bookkeeping
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic [15:0]      div_q;

    // Serializer state
    logic [2:0]  state;
    logic [15:0] baud_cnt;
    logic [15:0] div_lat;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_q;
    logic        parity_q;
    logic        tx_q;

    // Next-state values for the serializer
    logic [2:0]  nxt_state;
    logic [15:0] nxt_cnt;
    logic [15:0] nxt_div;
    logic [2:0]  nxt_idx;
    logic [7:0]  nxt_shift;
    logic        nxt_par;
    logic        nxt_tx;
    logic        pop;

    logic       fifo_empty;
    logic       fifo_full;
    logic       push_req;
    logic       push_ok;
    logic       flush;
    logic       ovf_clr;
    logic       busy;
    logic [7:0] fifo_head;
    logic       unused_ui;

    assign unused_ui  = ^ui_in;
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_CNT);
    assign fifo_head  = fifo_mem[rd_ptr];
    assign busy       = (state != ST_IDLE);

    assign push_req = data_write && (address == ADDR_TXDATA);
    assign flush    = data_write && (address == ADDR_CTRL) && data_in[0];
    assign ovf_clr  = data_write && (address == ADDR_CTRL) && data_in[1];
    // A full FIFO still accepts a push when the serializer pops in the same cycle.
    assign push_ok  = push_req && !flush && (!fifo_full || pop);

    // FIFO data storage (no reset needed; validity tracked by count)
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= data_in;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push_ok) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push_ok, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
            if (ovf_clr) begin
                overflow <= 1'b0;
            end else if (push_req && !flush && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Baud divisor register, byte-writable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= DIV_RESET;
        end else if (data_write) begin
            if (address == ADDR_DIV_LO) begin
                div_q[7:0] <= data_in;
            end else if (address == ADDR_DIV_HI) begin
                div_q[15:8] <= data_in;
            end
        end
    end

    // Serializer next-state logic; tx is derived from the next state so the
    // line comes straight off a flop
    always_comb begin
        nxt_state = state;
        nxt_cnt   = baud_cnt;
        nxt_div   = div_lat;
        nxt_idx   = bit_idx;
        nxt_shift = shift_q;
        nxt_par   = parity_q;
        pop       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    nxt_state = ST_START;
                    nxt_shift = fifo_head;
                    nxt_par   = ^fifo_head;
                    nxt_div   = div_q;
                    nxt_cnt   = div_q;
                end
            end
            ST_START: begin
                if (baud_cnt == '0) begin
                    nxt_state = ST_DATA;
                    nxt_idx   = '0;
                    nxt_cnt   = div_lat;
                end else begin
                    nxt_cnt = baud_cnt - 16'd1;
                end
            end
            ST_DATA: begin
                if (baud_cnt == '0) begin
                    nxt_cnt = div_lat;
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        nxt_state = ST_PARITY;
`else
                        nxt_state = ST_STOP;
`endif
                    end else begin
                        nxt_idx   = bit_idx + 3'd1;
                        nxt_shift = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    nxt_cnt = baud_cnt - 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_cnt == '0) begin
                    nxt_state = ST_STOP;
                    nxt_cnt   = div_lat;
                end else begin
                    nxt_cnt = baud_cnt - 16'd1;
                end
            end
`endif
            ST_STOP: begin
                if (baud_cnt == '0) begin
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        nxt_state = ST_START;
                        nxt_shift = fifo_head;
                        nxt_par   = ^fifo_head;
                        nxt_div   = div_q;
                        nxt_cnt   = div_q;
                    end else begin
                        nxt_state = ST_IDLE;
                    end
                end else begin
                    nxt_cnt = baud_cnt - 16'd1;
                end
            end
            default: begin
                nxt_state = ST_IDLE;
            end
        endcase

        case (nxt_state)
            ST_START: nxt_tx = 1'b0;
            ST_DATA:  nxt_tx = nxt_shift[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: nxt_tx = nxt_par;
`endif
            default:  nxt_tx = 1'b1;
        endcase
    end

    // Serializer registers; reset returns the line high immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            div_lat  <= DIV_RESET;
            bit_idx  <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state    <= nxt_state;
            baud_cnt <= nxt_cnt;
            div_lat  <= nxt_div;
            bit_idx  <= nxt_idx;
            shift_q  <= nxt_shift;
            parity_q <= nxt_par;
            tx_q     <= nxt_tx;
        end
    end

    assign uo_out = {7'b0000000, tx_q};

    // Combinational register read mux
    always_comb begin
        data_out = '0;
        case (address)
            ADDR_STATUS: data_out = {3'b000, PARITY_FEATURE, overflow, fifo_empty, fifo_full, busy};
            ADDR_DIV_LO: data_out = div_q[7:0];
            ADDR_DIV_HI: data_out = div_q[15:8];
            ADDR_COUNT:  data_out = {{(8 - CNT_W){1'b0}}, count};
            default:     data_out = '0;
        endcase
    end

endmodule

// File: tb/tb_tqvp_uart_tx_fifo.sv
// Self-checking bench for tqvp_uart_tx_fifo. A behavioural model keeps the
// queued bytes and the expected line bit stream; each clock the line, and
// regularly STATUS/COUNT, are compared against it.
module tb_tqvp_uart_tx_fifo;

    localparam logic [15:0] DIV_RESET = 16'd555;
    localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ui_in = '0;
    logic [7:0] uo_out;
    logic [3:0] address = '0;
    logic       data_write = 1'b0;
    logic [7:0] data_in = '0;
    logic [7:0] data_out;

    tqvp_uart_tx_fifo #(
        .FIFO_DEPTH(DEPTH),
        .DIV_RESET (DIV_RESET)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ui_in     (ui_in),
        .uo_out    (uo_out),
        .address   (address),
        .data_write(data_write),
        .data_in   (data_in),
        .data_out  (data_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit         line_q[$];
    logic [7:0] byte_q[$];
    logic [15:0] m_div = DIV_RESET;
    bit         m_ovf = 1'b0;
    bit         m_busy = 1'b0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    // One frame: start, 8 data bits LSB first, optional even parity, stop.
    function automatic void append_frame(input logic [7:0] b, input logic [15:0] d);
        int unsigned len;
        len = int'(d) + 1;
        for (int unsigned k = 0; k < len; k++) line_q.push_back(1'b0);
        for (int i = 0; i < 8; i++)
            for (int unsigned k = 0; k < len; k++) line_q.push_back(b[i]);
        if (PAR)
            for (int unsigned k = 0; k < len; k++) line_q.push_back(^b);
        for (int unsigned k = 0; k < len; k++) line_q.push_back(1'b1);
    endfunction

    function automatic logic [7:0] status_exp();
        return {3'b000, PAR, m_ovf, byte_q.size() == 0, byte_q.size() == DEPTH, m_busy};
    endfunction

    // Advance one clock: update the model with what the edge saw, then check tx.
    task automatic step();
        bit exp_tx;
        @(posedge clk);
        if (!rst_n) begin
            line_q.delete();
            byte_q.delete();
            m_div = DIV_RESET;
            m_ovf = 1'b0;
        end else begin
            // Line about to go idle and bytes waiting: next frame starts now.
            if (line_q.size() == 0 && byte_q.size() != 0)
                append_frame(byte_q.pop_front(), m_div);
            if (data_write) begin
                case (address)
                    4'h0: if (byte_q.size() < DEPTH) byte_q.push_back(data_in);
                          else m_ovf = 1'b1;
                    4'h2: m_div[7:0] = data_in;
                    4'h3: m_div[15:8] = data_in;
                    4'h4: begin
                        if (data_in[0]) byte_q.delete();
                        if (data_in[1]) m_ovf = 1'b0;
                    end
                    default: ;
                endcase
            end
        end
        #1;
        if (line_q.size() != 0) begin
            exp_tx = line_q.pop_front();
            m_busy = 1'b1;
        end else begin
            exp_tx = 1'b1;
            m_busy = 1'b0;
        end
        chk("tx", uo_out, {7'b0, exp_tx});
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        address = a;
        data_in = d;
        data_write = 1'b1;
        step();
        data_write = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
        address = a;
        #1;
        chk(tag, data_out, exp);
    endtask

    task automatic check_regs();
        rd_chk("status", 4'h1, status_exp());
        rd_chk("count", 4'h5, 8'(byte_q.size()));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            check_regs();
        end
    endtask

    // Run until the model says the serializer is idle, bounded by max cycles.
    task automatic drain(input int max);
        for (int i = 0; i < max; i++) begin
            if (line_q.size() == 0 && byte_q.size() == 0 && !m_busy) break;
            step();
            check_regs();
        end
        rd_chk("idle_status", 4'h1, {3'b000, PAR, m_ovf, 1'b1, 1'b0, 1'b0});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and register defaults
        repeat (3) step();
        rst_n = 1'b1;
        rd_chk("rst_status", 4'h1, {3'b000, PAR, 4'b0100});
        rd_chk("rst_count", 4'h5, 8'h00);
        rd_chk("rst_div_lo", 4'h2, 8'h2B);
        rd_chk("rst_div_hi", 4'h3, 8'h02);
        rd_chk("rst_txdata", 4'h0, 8'h00);
        rd_chk("rst_ctrl", 4'h4, 8'h00);
        rd_chk("rst_unmapped", 4'hF, 8'h00);
        chk("rst_uo_out", uo_out, 8'h01);
        run(2);

        // Single frame, DIV = 3
        wr(4'h2, 8'h03);
        wr(4'h3, 8'h00);
        rd_chk("div_lo_rb", 4'h2, 8'h03);
        rd_chk("div_hi_rb", 4'h3, 8'h00);
        wr(4'h0, 8'hA5);
        check_regs();
        drain(200);

        // Fill: long first frame lets 16 bytes queue up, 18th write overflows
        wr(4'h2, 8'd40);
        for (int i = 0; i < 17; i++) wr(4'h0, 8'(8'h30 + i));
        rd_chk("fill_count", 4'h5, 8'd16);
        rd_chk("fill_status", 4'h1, {3'b000, PAR, 4'b0011});
        wr(4'h0, 8'hEE);
        rd_chk("ovf_status", 4'h1, {3'b000, PAR, 4'b1011});
        rd_chk("ovf_count", 4'h5, 8'd16);
        // Remaining frames go out at DIV = 0, back to back
        wr(4'h2, 8'h00);
        drain(2000);

        // Flush mid-frame, then clear overflow
        wr(4'h2, 8'h03);
        wr(4'h0, 8'h11);
        wr(4'h0, 8'h22);
        wr(4'h0, 8'h33);
        run(8);
        wr(4'h4, 8'h01);
        rd_chk("flush_count", 4'h5, 8'h00);
        drain(200);
        wr(4'h4, 8'h02);
        rd_chk("ovf_clear", 4'h1, {3'b000, PAR, 4'b0100});

        // Divisor change takes effect on the following frame
        wr(4'h0, 8'h3C);
        wr(4'h0, 8'hC3);
        run(6);
        wr(4'h2, 8'h07);
        drain(400);

        // Parity-sensitive byte
        wr(4'h2, 8'h01);
        wr(4'h0, 8'h07);
        drain(200);

        // Randomized bursts
        for (int r = 0; r < 6; r++) begin
            int n;
            wr(4'h2, 8'($urandom_range(0, 4)));
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) begin
                wr(4'h0, 8'($urandom));
                run($urandom_range(0, 12));
            end
            drain(2000);
        end

        // Reset mid-DATA: line returns high without waiting for a clock
        wr(4'h2, 8'h03);
        wr(4'h0, 8'h5A);
        run(10);
        rst_n = 1'b0;
        #1;
        chk("async_rst_tx", uo_out, 8'h01);
        rd_chk("async_rst_status", 4'h1, {3'b000, PAR, 4'b0100});
        step();
        step();
        rst_n = 1'b1;
        rd_chk("post_rst_div_lo", 4'h2, 8'h2B);
        rd_chk("post_rst_count", 4'h5, 8'h00);
        run(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
